imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the instruction memory: streams a program image into the writable
//  IMEM array over a valid/ready word interface, then pads every unused location with NOP.
//  Sits between the boot/debug host link and the IMEM write port.
//  Holds the pipeline (cpu_hold) while the image is written, so fetch never sees a partial program.
// PARAMETERS
//  N       32  instruction word width
//  ADDR_W  6   IMEM address width; DEPTH = 2**ADDR_W = 64 words
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       1-cycle request to begin a load; sampled only in IDLE
//  len        in   ADDR_W+1  word count of image, sampled with start
//  in_valid   in   1       host word valid
//  in_data    in   N       host instruction word
//  in_ready   out  1       loader accepts in_data this cycle
//  mem_we     out  1       IMEM write enable (registered)
//  mem_addr   out  ADDR_W  IMEM write address (registered)
//  mem_wdata  out  N       IMEM write data (registered)
//  cpu_hold   out  1       pipeline hold while loading
//  done       out  1       1-cycle pulse: load complete
//  err        out  1       checksum mismatch, sticky (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, mem_we, cpu_hold, done, err = 0; mem_addr=0; mem_wdata=0.
//   Reset mid-load aborts immediately; IMEM keeps the words already written; no rollback.
//  States: IDLE -> LOAD -> [CHECK] -> FILL -> DONE -> IDLE.
//  IDLE: start=1 -> latch cnt=min(len,DEPTH), clear err, addr=0, cpu_hold=1.
//   Next state is LOAD if cnt!=0; FILL if cnt==0 (whole array becomes NOP).
//   start while not IDLE is ignored.
//  LOAD: in_ready=1. A transfer (in_valid&in_ready) at edge k drives mem_we=1, mem_addr=addr,
//   mem_wdata=in_data during cycle k+1. addr increments on each transfer; no transfer leaves addr and cnt unchanged.
//   After the cnt-th transfer the next state is CHECK if enabled, else FILL; FILL is skipped when cnt==DEPTH.
//  FILL: in_ready=0; one write per cycle of NOP (32'h00000000) at addr, addr+1, ..., DEPTH-1.
//   addr wraps to 0 only on exit; no write ever targets an address twice in one load.
//  DONE: one cycle; done=1. cpu_hold drops on the same edge done falls (IDLE re-entry).
//  Latency: start to done pulse = 1 + (data stall cycles) + DEPTH write cycles + [CHECK] + 1.
//  mem_we is 0 in IDLE, DONE and CHECK, and on LOAD cycles with no prior transfer.
//  len>DEPTH is clamped to DEPTH. Words arriving outside LOAD/CHECK are not accepted (in_ready=0).
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: CHECK state follows LOAD.
//   - One extra word is accepted there; it is compared against the XOR of all cnt loaded words.
//   - The extra word is not written to IMEM.
//   - Mismatch sets err=1 (held until next accepted start). done pulses regardless.
//  Not defined: no CHECK state, no accumulator, err tied 0.
// STRUCTURE
//  imem_pkg: IMEM_DEPTH, IMEM_AW, INSTR_NOP = 32'h0, loader_state_t enum {IDLE,LOAD,CHECK,FILL,DONE}.
//  Single module; the XOR accumulator is inline under the macro. No sub-module.
// TESTING
//  1. len=4, words 91003fe1,00000000,00000000,f8000001, in_valid continuous:
//     -> writes to addr 0..3 with those words, then NOP to 4..63;
//     -> done pulse 66 cycles after start; cpu_hold high throughout.
//  2. len=64, in_valid toggling 1/0 -> 64 writes to addr 0..63, no FILL writes;
//     -> mem_we low on every stall cycle; done follows the last write by 1 cycle.
//  3. len=0 -> 64 NOP writes to addr 0..63, in_ready never asserted; len=100 -> behaves as 64.
//  4. reset asserted after 2 of 4 words -> outputs 0 asynchronously;
//     -> addr 0..1 hold written data; a new start restarts at addr 0.
//  5. start pulsed during LOAD -> ignored; cnt and addr unaffected.
//  6. IMEM_LOADER_CHECKSUM_EN: len=2, words 0000000f, 000000f0:
//     -> check word 000000ff gives err=0, 000000fe gives err=1;
//     -> check word never written; err clears on the next start.

Source files
------------

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
//   Shared constants and types for the instruction-memory loader.
//   IMEM_AW     : IMEM address width (64-word array)
//   IMEM_DEPTH  : number of IMEM words
//   INSTR_NOP   : encoding written into every location the image does not cover
//   loader_state_t : loader FSM states
// ---------------------------------------------------------------------------
package imem_pkg;

    localparam int          IMEM_AW    = 6;
    localparam int          IMEM_DEPTH = 2 ** IMEM_AW;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        FILL,
        DONE
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Streams a program image from the boot/debug host link into the writable
//   IMEM array, then pads every remaining location with NOP. The CPU pipeline
//   is held for the whole load so fetch never observes a partial program.
//
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//     When defined, one extra word follows the image; it is compared against
//     the XOR of all image words and a mismatch raises the sticky err flag.
//     When undefined, there is no CHECK phase and err is tied low.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle load request, honoured only while idle
//   len        in   image word count, sampled with start (clamped to depth)
//   in_valid   in   host word valid
//   in_data    in   host instruction word
//   in_ready   out  loader accepts in_data this cycle
//   mem_we     out  registered IMEM write enable
//   mem_addr   out  registered IMEM write address
//   mem_wdata  out  registered IMEM write data
//   cpu_hold   out  pipeline hold while loading
//   done       out  one-cycle completion pulse
//   err        out  sticky checksum mismatch flag
// ---------------------------------------------------------------------------
module imem_loader
    import imem_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = IMEM_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [N-1:0]      in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [N-1:0]    NOP_WORD  = N'(INSTR_NOP);

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0]      mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [N-1:0]      acc_q, acc_d;
    logic              err_q, err_d;
`endif

    logic              xfer;
    logic              start_ok;
    logic [ADDR_W:0]   len_clamped;
    logic              last_word;
    logic              fill_last;
    loader_state_t     after_data;

    // Handshake and decode helpers shared by the FSM and the datapath.
    // last_word compares the post-increment address with the latched count,
    // so a full 64-word image is recognised even though addr itself wraps.
    // after_data skips FILL entirely when the image already covers the array.
    always_comb begin
        xfer        = in_valid & in_ready;
        start_ok    = start & (state_q == IDLE);
        len_clamped = (len > DEPTH_CNT) ? DEPTH_CNT : len;
        last_word   = (({1'b0, addr_q} + (ADDR_W + 1)'(1)) == cnt_q);
        fill_last   = &addr_q;
        after_data  = (cnt_q == DEPTH_CNT) ? DONE : FILL;
    end

    // State register and all datapath/output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_q       <= acc_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state logic. An empty image goes straight to FILL so the whole
    // array is overwritten with NOP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = (len_clamped == '0) ? FILL : LOAD;
                end
            end
            LOAD: begin
                if (xfer && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = after_data;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    state_d = after_data;
                end
            end
`endif
            FILL: begin
                if (fill_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address/count bookkeeping and the optional checksum accumulator.
    // addr advances once per accepted word and once per FILL write; after
    // 63 it wraps to 0, which only ever happens on the way out of the load.
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc_d  = acc_q;
        err_d  = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    cnt_d  = len_clamped;
                    addr_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    acc_d  = '0;
                    err_d  = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (xfer) begin
                    addr_d = addr_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    acc_d  = acc_q ^ in_data;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer && (in_data != acc_q)) begin
                    err_d = 1'b1;
                end
            end
`endif
            FILL: begin
                addr_d = addr_q + 1'b1;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Output logic. Write outputs are registered one cycle behind the
    // accepting edge; address/data hold their last value between writes.
    // done is the registered image of the DONE state, and cpu_hold stays
    // asserted through that pulse so both fall on the same edge.
    always_comb begin
        in_ready    = (state_q == LOAD) || (state_q == CHECK);
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            LOAD: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                end
            end
            FILL: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = NOP_WORD;
            end
            default: begin
                mem_we_d = 1'b0;
            end
        endcase
        done_d     = (state_q == DONE);
        cpu_hold_d = (state_d != IDLE) || (state_q == DONE);
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. A negedge monitor builds a shadow copy of
//   IMEM from the write port; the directed sequence compares it, the write
//   counts and the start-to-done latency against hand-computed values.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int passes = 0;

    logic [31:0] shadow [64];
    int          hits   [64];
    int          total_writes;
    int          first_addr;
    int          done_pulses;
    int          done_cycle;
    int          last_we_cycle;
    int          ready_seen;
    int          hold_low;
    int          we_bad;
    int          start_cycle;
    bit          loading;
    bit          track_we;
    bit          xfer_pending;
    int          cycle = 0;

    imem_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Write-port monitor, sampled mid-cycle. It records every IMEM write,
    // the done pulse, and (when enabled) whether each write cycle was
    // preceded by an accepted host word.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (first_addr < 0) first_addr = int'(mem_addr);
                shadow[mem_addr] = mem_wdata;
                hits[mem_addr]   = hits[mem_addr] + 1;
                total_writes     = total_writes + 1;
                last_we_cycle    = cycle;
            end
            if (track_we && (mem_we !== xfer_pending)) we_bad = we_bad + 1;
            xfer_pending = in_valid && in_ready;
            if (loading && in_ready) ready_seen = ready_seen + 1;
            if (loading && !cpu_hold) hold_low = hold_low + 1;
            if (done) begin
                done_pulses = done_pulses + 1;
                done_cycle  = cycle;
                loading     = 1'b0;
            end
        end
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) passes = passes + 1;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin
            shadow[i] = 32'hDEAD_BEEF;
            hits[i]   = 0;
        end
        total_writes  = 0;
        first_addr    = -1;
        done_pulses   = 0;
        done_cycle    = 0;
        last_we_cycle = 0;
        ready_seen    = 0;
        hold_low      = 0;
        we_bad        = 0;
        loading       = 1'b0;
        track_we      = 1'b0;
        xfer_pending  = 1'b0;
    endtask

    function automatic int hits_bad();
        int n = 0;
        for (int i = 0; i < 64; i++) if (hits[i] != 1) n++;
        return n;
    endfunction

    function automatic int nop_bad(input int from);
        int n = 0;
        for (int i = from; i < 64; i++) if (shadow[i] !== 32'h0) n++;
        return n;
    endfunction

    // Pulse start for one cycle; start_cycle marks the cycle start is high.
    task automatic apply_start(input logic [6:0] l);
        @(posedge clk);
        #1;
        start       = 1'b1;
        len         = l;
        start_cycle = cycle;
        @(posedge clk);
        #1;
        start   = 1'b0;
        loading = 1'b1;
    endtask

    // Offer one word and hold it until the loader accepts it.
    task automatic apply_word(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("in_ready_wait", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the done pulse, then confirm hold and done fall together.
    task automatic wait_done(input int limit);
        int n = 0;
        while (done_pulses == 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_output("done_seen", done_pulses, 1);
        @(negedge clk);
        #1;
        check_output("hold_drop", cpu_hold, 1'b0);
        check_output("done_single", done_pulses, 1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check_output("rst_in_ready", in_ready, 1'b0);
        check_output("rst_mem_we", mem_we, 1'b0);
        check_output("rst_mem_addr", mem_addr, 6'd0);
        check_output("rst_mem_wdata", mem_wdata, 32'h0);
        check_output("rst_cpu_hold", cpu_hold, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_err", err, 1'b0);
        reset = 1'b0;

        // Short image, continuous valid, NOP padding
        $display("[TB] len=4 continuous");
        clear_model();
        apply_start(7'd4);
        apply_word(32'h91003fe1);
        apply_word(32'h00000000);
        apply_word(32'h00000000);
        apply_word(32'hf8000001);
        wait_done(300);
        check_output("t1_w0", shadow[0], 32'h91003fe1);
        check_output("t1_w1", shadow[1], 32'h00000000);
        check_output("t1_w2", shadow[2], 32'h00000000);
        check_output("t1_w3", shadow[3], 32'hf8000001);
        check_output("t1_nop_fill", nop_bad(4), 0);
        check_output("t1_hits", hits_bad(), 0);
        check_output("t1_writes", total_writes, 64);
        check_output("t1_latency", done_cycle - start_cycle, 66);
        check_output("t1_hold_high", hold_low, 0);
        check_output("t1_err", err, 1'b0);

        // Full image with a stall between every word
        $display("[TB] len=64 toggling valid");
        clear_model();
        track_we = 1'b1;
        apply_start(7'd64);
        for (int i = 0; i < 64; i++) begin
            apply_word((32'(i) * 32'h01010101) ^ 32'hA5000000);
            if (i < 63) begin
                @(posedge clk);
                #1;
            end
        end
        wait_done(300);
        track_we = 1'b0;
        begin
            int bad = 0;
            for (int i = 0; i < 64; i++)
                if (shadow[i] !== ((32'(i) * 32'h01010101) ^ 32'hA5000000)) bad++;
            check_output("t2_data", bad, 0);
        end
        check_output("t2_writes", total_writes, 64);
        check_output("t2_hits", hits_bad(), 0);
        check_output("t2_we_stall", we_bad, 0);
        check_output("t2_done_after_we", done_cycle - last_we_cycle, 1);
        check_output("t2_latency", done_cycle - start_cycle, 129);

        // Empty image: whole array becomes NOP, host never handshaked
        $display("[TB] len=0");
        clear_model();
        apply_start(7'd0);
        wait_done(300);
        check_output("t3_writes", total_writes, 64);
        check_output("t3_nop", nop_bad(0), 0);
        check_output("t3_hits", hits_bad(), 0);
        check_output("t3_no_ready", ready_seen, 0);
        check_output("t3_latency", done_cycle - start_cycle, 66);

        // Oversized length clamps to the array depth
        $display("[TB] len=100");
        clear_model();
        apply_start(7'd100);
        for (int i = 0; i < 64; i++) apply_word(32'hC0DE0000 | 32'(i));
        wait_done(300);
        begin
            int bad = 0;
            for (int i = 0; i < 64; i++)
                if (shadow[i] !== (32'hC0DE0000 | 32'(i))) bad++;
            check_output("t3b_data", bad, 0);
        end
        check_output("t3b_writes", total_writes, 64);
        check_output("t3b_latency", done_cycle - start_cycle, 66);
        check_output("t3b_ready_after", in_ready, 1'b0);

        // Reset in the middle of a load
        $display("[TB] reset mid-load");
        clear_model();
        apply_start(7'd4);
        apply_word(32'h11111111);
        apply_word(32'h22222222);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("t4_we", mem_we, 1'b0);
        check_output("t4_addr", mem_addr, 6'd0);
        check_output("t4_wdata", mem_wdata, 32'h0);
        check_output("t4_hold", cpu_hold, 1'b0);
        check_output("t4_ready", in_ready, 1'b0);
        check_output("t4_w0", shadow[0], 32'h11111111);
        check_output("t4_w1", shadow[1], 32'h22222222);
        check_output("t4_writes", total_writes, 2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        apply_start(7'd4);
        apply_word(32'hAAAA0000);
        apply_word(32'hAAAA0001);
        apply_word(32'hAAAA0002);
        apply_word(32'hAAAA0003);
        wait_done(300);
        check_output("t4_first_addr", first_addr, 0);
        check_output("t4_r0", shadow[0], 32'hAAAA0000);
        check_output("t4_r3", shadow[3], 32'hAAAA0003);
        check_output("t4_rwrites", total_writes, 64);

        // Start pulsed while loading is ignored
        $display("[TB] start during LOAD");
        clear_model();
        apply_start(7'd4);
        apply_word(32'h50000000);
        apply_word(32'h50000001);
        start = 1'b1;
        len   = 7'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        apply_word(32'h50000002);
        apply_word(32'h50000003);
        wait_done(300);
        check_output("t5_w0", shadow[0], 32'h50000000);
        check_output("t5_w2", shadow[2], 32'h50000002);
        check_output("t5_w3", shadow[3], 32'h50000003);
        check_output("t5_nop", nop_bad(4), 0);
        check_output("t5_hits", hits_bad(), 0);
        check_output("t5_latency", done_cycle - start_cycle, 67);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum word: correct, then wrong, then cleared by a new start
        $display("[TB] checksum");
        clear_model();
        apply_start(7'd2);
        apply_word(32'h0000000f);
        apply_word(32'h000000f0);
        apply_word(32'h000000ff);
        wait_done(300);
        check_output("t6_err_ok", err, 1'b0);
        check_output("t6_no_chk_write", shadow[2], 32'h0);
        check_output("t6_hits", hits_bad(), 0);
        check_output("t6_writes", total_writes, 64);
        check_output("t6_latency", done_cycle - start_cycle, 67);
        clear_model();
        apply_start(7'd2);
        apply_word(32'h0000000f);
        apply_word(32'h000000f0);
        apply_word(32'h000000fe);
        wait_done(300);
        check_output("t6_err_bad", err, 1'b1);
        @(negedge clk);
        check_output("t6_err_sticky", err, 1'b1);
        clear_model();
        apply_start(7'd2);
        check_output("t6_err_clear", err, 1'b0);
        apply_word(32'h0000000f);
        apply_word(32'h000000f0);
        apply_word(32'h000000ff);
        wait_done(300);
        check_output("t6_err_final", err, 1'b0);
`else
        check_output("err_tied_low", err, 1'b0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
